// File: rtl/regfile_wr_arb_if.sv
// Write-port bundle for regfile_wr_arb: core and IO request/grant
// channels plus the registered regfile write port and busy flag.
interface regfile_wr_arb_if;
    logic       core_req;
    logic [3:0] core_wa;
    logic [7:0] core_wd;
    logic       core_gnt;
    logic       io_req;
    logic [3:0] io_wa;
    logic [7:0] io_wd;
    logic       io_gnt;
    logic       io_lock;
    logic       we3;
    logic [3:0] wa3;
    logic [7:0] wd3;
    logic       busy;

    modport master (
        output core_req, core_wa, core_wd,
        output io_req, io_wa, io_wd, io_lock,
        input  core_gnt, io_gnt,
        input  we3, wa3, wd3, busy
    );

    modport slave (
        input  core_req, core_wa, core_wd,
        input  io_req, io_wa, io_wd, io_lock,
        output core_gnt, io_gnt,
        output we3, wa3, wd3, busy
    );
endinterface

// File: rtl/regfile_wr_arb.sv
// Round-robin regfile write arbiter (core vs IO), one registered write
// per cycle, latency 1; writes to r0 handshake but never raise we3.
// Ports: clk, reset (async, active low), bus (regfile_wr_arb_if.slave).
// Optional IO burst ownership enabled by macro REGARB_BURST_EN.
module regfile_wr_arb #(
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    regfile_wr_arb_if.slave  bus
);

`ifdef REGARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    localparam logic [2:0] BMAX = 3'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE, LAST_CORE, LAST_IO, BURST
    } state_e;

    state_e     state_q, state_d;
    logic       last_io_q, last_io_d;
    logic [2:0] cnt_q, cnt_d;
    logic       we3_q, we3_d;
    logic       busy_q, busy_d;
    logic [3:0] wa3_q, wa3_d;
    logic [7:0] wd3_q, wd3_d;

    logic core_gnt, io_gnt;
    logic burst_hold;
    logic hs_core, hs_io;

    // IO keeps priority only while its burst is still within budget
    assign burst_hold = BURST_EN && (state_q == BURST) &&
                        bus.io_lock && (cnt_q < BMAX);

    assign hs_core = bus.core_req & core_gnt;
    assign hs_io   = bus.io_req & io_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_io_q <= 1'b1;
            cnt_q     <= 3'd0;
            we3_q     <= 1'b0;
            busy_q    <= 1'b0;
            wa3_q     <= 4'd0;
            wd3_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            last_io_q <= last_io_d;
            cnt_q     <= cnt_d;
            we3_q     <= we3_d;
            busy_q    <= busy_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
        end
    end

    always_comb begin
        state_d   = IDLE;
        last_io_d = last_io_q;
        cnt_d     = 3'd0;
        if (hs_core) begin
            state_d   = LAST_CORE;
            last_io_d = 1'b0;
        end else if (hs_io) begin
            last_io_d = 1'b1;
            if (BURST_EN && bus.io_lock) begin
                state_d = BURST;
                // an exhausted burst regranted to a lone IO starts afresh
                cnt_d = burst_hold ? cnt_q + 3'd1 : 3'd1;
            end else begin
                state_d = LAST_IO;
            end
        end
    end

    // Grants are gated by reset so nothing handshakes while held in reset
    always_comb begin
        core_gnt = 1'b0;
        io_gnt   = 1'b0;
        if (!reset) begin
            core_gnt = 1'b0;
        end else if (burst_hold && bus.io_req) begin
            io_gnt = 1'b1;
        end else if (bus.core_req && bus.io_req) begin
            core_gnt = last_io_q;
            io_gnt   = !last_io_q;
        end else begin
            core_gnt = bus.core_req;
            io_gnt   = bus.io_req;
        end
    end

    always_comb begin
        we3_d  = 1'b0;
        busy_d = 1'b0;
        wa3_d  = wa3_q;
        wd3_d  = wd3_q;
        if (hs_core) begin
            busy_d = 1'b1;
            we3_d  = |bus.core_wa;
            wa3_d  = bus.core_wa;
            wd3_d  = bus.core_wd;
        end else if (hs_io) begin
            busy_d = 1'b1;
            we3_d  = |bus.io_wa;
            wa3_d  = bus.io_wa;
            wd3_d  = bus.io_wd;
        end
    end

    assign bus.core_gnt = core_gnt;
    assign bus.io_gnt   = io_gnt;
    assign bus.we3      = we3_q;
    assign bus.busy     = busy_q;
    assign bus.wa3      = wa3_q;
    assign bus.wd3      = wd3_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb: reset, single writes, r0 write,
// round-robin, reset abort, and burst / plain alternation sequence.
module tb_regfile_wr_arb;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    regfile_wr_arb_if bus ();

    regfile_wr_arb #(.BURST_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.core_req = 1'b0;
        bus.io_req   = 1'b0;
        bus.io_lock  = 1'b0;
    endtask

    // 1 = core expected to win, 0 = IO
    logic [7:0] seq_exp;

    initial begin
        reset       = 1'b0;
        bus.core_wa = 4'd0;
        bus.core_wd = 8'd0;
        bus.io_wa   = 4'd0;
        bus.io_wd   = 8'd0;
        idle_inputs();

        // reset holds everything low even with a request pending
        neg();
        bus.core_req = 1'b1;
        bus.core_wa  = 4'd3;
        bus.core_wd  = 8'h5A;
        #1;
        chk("rst_core_gnt", 8'(bus.core_gnt), 8'd0);
        chk("rst_io_gnt", 8'(bus.io_gnt), 8'd0);
        chk("rst_we3", 8'(bus.we3), 8'd0);
        chk("rst_busy", 8'(bus.busy), 8'd0);
        chk("rst_wa3", 8'(bus.wa3), 8'd0);
        chk("rst_wd3", 8'(bus.wd3), 8'd0);
        pos();
        chk("rst_we3_edge", 8'(bus.we3), 8'd0);

        // first edge after release completes the core write
        neg();
        reset = 1'b1;
        #1;
        chk("c1_core_gnt", 8'(bus.core_gnt), 8'd1);
        chk("c1_io_gnt", 8'(bus.io_gnt), 8'd0);
        pos();
        chk("c1_we3", 8'(bus.we3), 8'd1);
        chk("c1_wa3", 8'(bus.wa3), 8'd3);
        chk("c1_wd3", 8'(bus.wd3), 8'h5A);
        chk("c1_busy", 8'(bus.busy), 8'd1);
        neg();
        idle_inputs();
        pos();
        chk("c1_we3_drop", 8'(bus.we3), 8'd0);
        chk("c1_busy_drop", 8'(bus.busy), 8'd0);
        chk("c1_wa3_hold", 8'(bus.wa3), 8'd3);
        chk("c1_wd3_hold", 8'(bus.wd3), 8'h5A);

        // r0 write from IO: handshake, busy, but no we3
        neg();
        bus.io_req = 1'b1;
        bus.io_wa  = 4'd0;
        bus.io_wd  = 8'hFF;
        #1;
        chk("r0_io_gnt", 8'(bus.io_gnt), 8'd1);
        chk("r0_core_gnt", 8'(bus.core_gnt), 8'd0);
        pos();
        chk("r0_we3", 8'(bus.we3), 8'd0);
        chk("r0_busy", 8'(bus.busy), 8'd1);
        chk("r0_wa3", 8'(bus.wa3), 8'd0);
        chk("r0_wd3", 8'(bus.wd3), 8'hFF);

        // continuous contention: IO went last, so core starts
        neg();
        bus.core_req = 1'b1;
        bus.core_wa  = 4'd1;
        bus.core_wd  = 8'h11;
        bus.io_req   = 1'b1;
        bus.io_wa    = 4'd2;
        bus.io_wd    = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d_core_gnt", i), 8'(bus.core_gnt),
                8'((i % 2) == 0));
            chk($sformatf("rr%0d_io_gnt", i), 8'(bus.io_gnt),
                8'((i % 2) == 1));
            pos();
            chk($sformatf("rr%0d_we3", i), 8'(bus.we3), 8'd1);
            chk($sformatf("rr%0d_wa3", i), 8'(bus.wa3),
                ((i % 2) == 0) ? 8'd1 : 8'd2);
            neg();
        end
        idle_inputs();
        pos();
        chk("rr_end_we3", 8'(bus.we3), 8'd0);

        // reset the cycle after an accepted write aborts everything
        neg();
        bus.core_req = 1'b1;
        bus.core_wa  = 4'd5;
        bus.core_wd  = 8'h33;
        pos();
        chk("ra_we3_pre", 8'(bus.we3), 8'd1);
        neg();
        reset = 1'b0;
        #1;
        chk("ra_we3", 8'(bus.we3), 8'd0);
        chk("ra_wa3", 8'(bus.wa3), 8'd0);
        chk("ra_wd3", 8'(bus.wd3), 8'd0);
        chk("ra_busy", 8'(bus.busy), 8'd0);
        chk("ra_core_gnt", 8'(bus.core_gnt), 8'd0);
        pos();
        neg();
        idle_inputs();
        reset = 1'b1;
        pos();
        chk("ra_we3_post", 8'(bus.we3), 8'd0);
        chk("ra_busy_post", 8'(bus.busy), 8'd0);

        // contention with io_lock held
`ifdef REGARB_BURST_EN
        seq_exp = 8'b0010_0001;
`else
        seq_exp = 8'b0101_0101;
`endif
        neg();
        bus.core_req = 1'b1;
        bus.core_wa  = 4'd1;
        bus.io_req   = 1'b1;
        bus.io_wa    = 4'd2;
        bus.io_lock  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("bl%0d_core_gnt", i), 8'(bus.core_gnt),
                8'(seq_exp[i]));
            chk($sformatf("bl%0d_io_gnt", i), 8'(bus.io_gnt),
                8'(!seq_exp[i]));
            pos();
            chk($sformatf("bl%0d_wa3", i), 8'(bus.wa3),
                seq_exp[i] ? 8'd1 : 8'd2);
            neg();
        end
        idle_inputs();
        pos();
        chk("bl_end_we3", 8'(bus.we3), 8'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
